// File: rtl/kb_pkg.sv
// rtl/kb_pkg.sv - shared constants, FSM state type and byte classifier for the keyboard scan sequencer
//
// Contents:
//   KB_BREAK / KB_EXT        prefix bytes (F0 break, E0 extended)
//   KB_IGN_*                 non-key bytes the keyboard emits (errors, BAT, echo, ack, resend)
//   kb_state_e               make/break/extended protocol state
//   kb_is_ignored()          true for bytes that never denote a key
package kb_pkg;

  localparam logic [7:0] KB_BREAK      = 8'hF0;
  localparam logic [7:0] KB_EXT        = 8'hE0;

  localparam logic [7:0] KB_IGN_ERR0   = 8'h00;
  localparam logic [7:0] KB_IGN_BAT    = 8'hAA;
  localparam logic [7:0] KB_IGN_ECHO   = 8'hEE;
  localparam logic [7:0] KB_IGN_ACK    = 8'hFA;
  localparam logic [7:0] KB_IGN_RESEND = 8'hFE;
  localparam logic [7:0] KB_IGN_ERR1   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } kb_state_e;

  function automatic logic kb_is_ignored(input logic [7:0] b);
    return (b == KB_IGN_ERR0) || (b == KB_IGN_BAT)    || (b == KB_IGN_ECHO) ||
           (b == KB_IGN_ACK)  || (b == KB_IGN_RESEND) || (b == KB_IGN_ERR1);
  endfunction

endpackage

// File: rtl/kb_scan_ctrl_if.sv
// rtl/kb_scan_ctrl_if.sv - scan-byte input and key-code output bundle of the keyboard scan sequencer
//
// Signals:
//   scan_done_tick  one-cycle pulse, scan_out holds a fresh PS/2 byte
//   scan_out[7:0]   received byte
//   key_ready       consumer accepts the head key code this cycle
//   key_valid       key queue non-empty
//   key_code[7:0]   head-of-queue make code (00 when empty)
//   overflow        sticky, a key was dropped on a full queue
//   key_held        a non-extended key is currently down
// Modports:
//   master  byte source / key consumer side
//   slave   the sequencer itself
interface kb_scan_ctrl_if;

  logic       scan_done_tick;
  logic [7:0] scan_out;
  logic       key_ready;
  logic       key_valid;
  logic [7:0] key_code;
  logic       overflow;
  logic       key_held;

  modport master (
    output scan_done_tick,
    output scan_out,
    output key_ready,
    input  key_valid,
    input  key_code,
    input  overflow,
    input  key_held
  );

  modport slave (
    input  scan_done_tick,
    input  scan_out,
    input  key_ready,
    output key_valid,
    output key_code,
    output overflow,
    output key_held
  );

endinterface

// File: rtl/kb_fifo.sv
// rtl/kb_fifo.sv - first-word-fall-through queue for key codes
//
// Parameters: DEPTH (power of two, 2..16), WIDTH (entry width)
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write request and data; dropped when full unless a pop frees a slot
//   pop             read request; ignored when empty
//   head_data       current head entry, zero whenever empty
//   full, empty     occupancy flags
module kb_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

  // A pop on a full queue frees the slot the same-cycle push lands in.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Head is read straight from storage, so it only moves on a pop or on the
  // first write into an empty queue.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/kb_scan_ctrl.sv
// rtl/kb_scan_ctrl.sv - PS/2 make/break/extended sequencer feeding a key-code queue
//
// Parameters: FIFO_DEPTH (key queue entries), TIMEOUT (cycles allowed after a prefix byte)
// Ports:
//   clk     system clock
//   reset   asynchronous active-low reset
//   kb      kb_scan_ctrl_if.slave: scan_done_tick/scan_out in, key_ready in,
//           key_valid/key_code/overflow/key_held out
module kb_scan_ctrl
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic           clk,
  input  logic           reset,
  kb_scan_ctrl_if.slave  kb
);

  localparam int TW = $clog2(TIMEOUT + 1);

  kb_state_e   state_q, state_d;
  kb_state_e   cur_state;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        held_q, held_d;
  logic [7:0]  held_code_q, held_code_d;
  logic        ovf_q, ovf_d;

  logic        push;
  logic        pop_acc;
  logic        fifo_full;
  logic        fifo_empty;
  logic        tmo_fire;
  logic [7:0]  b;

  assign b       = kb.scan_out;
  assign pop_acc = ~fifo_empty & kb.key_ready;

  // The prefix window expires on the TIMEOUT-th cycle spent waiting; a byte
  // arriving on that very cycle is decoded as if already back in IDLE.
  assign tmo_fire  = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT - 1));
  assign cur_state = tmo_fire ? IDLE : state_q;

  always_comb begin
    state_d     = cur_state;
    held_d      = held_q;
    held_code_d = held_code_q;
    push        = 1'b0;

    if (kb.scan_done_tick) begin
      unique case (cur_state)
        IDLE: begin
          if (b == KB_BREAK) begin
            state_d = BRK;
          end else if (b == KB_EXT) begin
            state_d = EXT;
          end else if (!kb_is_ignored(b)) begin
            // Typematic repeat of the key already down is swallowed.
            if (!(held_q && (b == held_code_q))) begin
              push        = 1'b1;
              held_d      = 1'b1;
              held_code_d = b;
            end
          end
        end
        BRK: begin
          if (b == held_code_q) begin
            held_d = 1'b0;
          end
          state_d = IDLE;
        end
        EXT: begin
          state_d = (b == KB_BREAK) ? EXT_BRK : IDLE;
        end
        EXT_BRK: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Counter runs only while parked in a prefix state with no new byte.
    tmo_d = '0;
    if ((state_d != IDLE) && (state_d == state_q) && !kb.scan_done_tick) begin
      tmo_d = tmo_q + 1'b1;
    end

    // A drop only happens when no pop freed a slot, so set never meets clear;
    // set is still written first to make the priority explicit.
    if (push && fifo_full && !pop_acc) begin
      ovf_d = 1'b1;
    end else if (pop_acc) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      held_q      <= 1'b0;
      held_code_q <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      held_q      <= held_d;
      held_code_q <= held_code_d;
      ovf_q       <= ovf_d;
    end
  end

  kb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (b),
    .pop       (kb.key_ready),
    .head_data (kb.key_code),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign kb.key_valid = ~fifo_empty;
  assign kb.overflow  = ovf_q;
  assign kb.key_held  = held_q;

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// tb/tb_kb_scan_ctrl.sv - directed and randomized bench for kb_scan_ctrl against a behavioural key model
module tb_kb_scan_ctrl;

  localparam int DEPTH = 8;
  localparam int TMO   = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  kb_scan_ctrl_if kb_if ();

  kb_scan_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .kb    (kb_if)
  );

  // Behavioural model: list of queued keys, which key is down, and the
  // prefix bytes still waiting for their follower.
  logic [7:0] m_q [$];
  bit         m_held;
  logic [7:0] m_held_code;
  bit         m_ovf;
  bit         seen_f0;
  bit         seen_e0;
  int         cyc;
  int         pfx_cyc;
  int         n_cmp;
  int         n_bad;
  logic       ready_r;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_held      = 1'b0;
    m_held_code = 8'h00;
    m_ovf       = 1'b0;
    seen_f0     = 1'b0;
    seen_e0     = 1'b0;
  endtask

  task automatic model_edge(input bit tick, input logic [7:0] b, input bit rdy);
    bit pop;
    bit want_push;
    bit drop;
    pop       = (m_q.size() > 0) && rdy;
    want_push = 1'b0;
    drop      = 1'b0;
    if ((seen_f0 || seen_e0) && (cyc - pfx_cyc >= TMO)) begin
      seen_f0 = 1'b0;
      seen_e0 = 1'b0;
    end
    if (tick) begin
      if (seen_e0) begin
        if (!seen_f0 && b == 8'hF0) begin
          seen_f0 = 1'b1;
          pfx_cyc = cyc;
        end else begin
          seen_e0 = 1'b0;
          seen_f0 = 1'b0;
        end
      end else if (seen_f0) begin
        if (b == m_held_code) m_held = 1'b0;
        seen_f0 = 1'b0;
      end else if (b == 8'hF0) begin
        seen_f0 = 1'b1;
        pfx_cyc = cyc;
      end else if (b == 8'hE0) begin
        seen_e0 = 1'b1;
        pfx_cyc = cyc;
      end else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) &&
                   !(m_held && b == m_held_code)) begin
        want_push   = 1'b1;
        m_held      = 1'b1;
        m_held_code = b;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (want_push) begin
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (pop) m_ovf = 1'b0;
    cyc++;
  endtask

  task automatic check_outputs();
    chk("key_valid", kb_if.key_valid, (m_q.size() != 0));
    chk("key_code",  kb_if.key_code,  (m_q.size() != 0) ? m_q[0] : 8'h00);
    chk("overflow",  kb_if.overflow,  m_ovf);
    chk("key_held",  kb_if.key_held,  m_held);
  endtask

  task automatic step(input bit tick, input logic [7:0] b);
    kb_if.scan_done_tick = tick;
    kb_if.scan_out       = tick ? b : 8'($urandom);
    kb_if.key_ready      = ready_r;
    @(posedge clk);
    model_edge(tick, b, ready_r);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic drain();
    ready_r = 1'b1;
    idle(DEPTH + 1);
    ready_r = 1'b0;
    chk("drained", kb_if.key_valid, 1'b0);
  endtask

  task automatic do_reset();
    kb_if.scan_done_tick = 1'b0;
    kb_if.key_ready      = 1'b0;
    kb_if.scan_out       = 8'h00;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_valid", kb_if.key_valid, 1'b0);
    chk("rst_code",  kb_if.key_code,  8'h00);
    chk("rst_ovf",   kb_if.overflow,  1'b0);
    chk("rst_held",  kb_if.key_held,  1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  logic [7:0] nine [9];
  logic [7:0] pool [10];

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    cyc     = 0;
    pfx_cyc = 0;
    ready_r = 1'b0;
    nine = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    pool = '{8'h1C, 8'h32, 8'h5A, 8'hF0, 8'hF0, 8'hE0, 8'hAA, 8'hFF, 8'h00, 8'h75};
    model_clear();
    do_reset();

    // Make, break with nothing consumed.
    send(8'h1C);
    chk("t1_held_on", kb_if.key_held, 1'b1);
    send(8'hF0);
    send(8'h1C);
    chk("t1_code", kb_if.key_code, 8'h1C);
    chk("t1_held_off", kb_if.key_held, 1'b0);
    drain();

    // Typematic repeats collapse to one entry; a fresh press is new.
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    chk("t2_code", kb_if.key_code, 8'h1C);
    send(8'h1C);
    ready_r = 1'b1;
    idle(1);
    ready_r = 1'b0;
    chk("t2_second", kb_if.key_valid, 1'b1);
    send(8'hF0); send(8'h1C);
    drain();

    // Extended make/break are discarded.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h32);
    chk("t3_code", kb_if.key_code, 8'h32);
    ready_r = 1'b1;
    idle(1);
    ready_r = 1'b0;
    chk("t3_only32", kb_if.key_valid, 1'b0);
    send(8'hF0); send(8'h32);

    // Overflow on the ninth key, cleared by a pop.
    for (int i = 0; i < 9; i++) begin
      send(nine[i]); send(8'hF0); send(nine[i]);
    end
    chk("t4_ovf", kb_if.overflow, 1'b1);
    chk("t4_head", kb_if.key_code, 8'h16);
    ready_r = 1'b1;
    idle(1);
    ready_r = 1'b0;
    chk("t4_head2", kb_if.key_code, 8'h1E);
    chk("t4_ovf_clr", kb_if.overflow, 1'b0);
    drain();

    // Prefix timeout and its exact boundary.
    send(8'hF0); idle(TMO); send(8'h2D);
    chk("t5_code", kb_if.key_code, 8'h2D);
    drain();
    send(8'hF0); idle(TMO - 2); send(8'h2D);
    chk("t5_brk_valid", kb_if.key_valid, 1'b0);
    chk("t5_brk_held", kb_if.key_held, 1'b0);
    send(8'hF0); idle(TMO - 1); send(8'h2D);
    chk("t5_fire_code", kb_if.key_code, 8'h2D);
    drain();
    send(8'hF0); send(8'h2D);

    // Reset mid-sequence with three queued keys and a pending break.
    send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'h32); send(8'hF0); send(8'h32);
    send(8'h5A); send(8'hF0);
    chk("t6_pre_valid", kb_if.key_valid, 1'b1);
    do_reset();
    send(8'h5A);
    chk("t6_code", kb_if.key_code, 8'h5A);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) ready_r = 1'b0;
      if (i % 100 == 0) ready_r = 1'b1;
      if ((i / 50) % 2 == 0) ready_r = ($urandom_range(0, 3) == 0);
      else ready_r = ($urandom_range(0, 3) != 0);
      if (i == 1500) do_reset();
      if ($urandom_range(0, 60) == 0) begin
        idle($urandom_range(TMO - 3, TMO + 3));
      end else if ($urandom_range(0, 1) == 0) begin
        send(pool[$urandom_range(0, 9)]);
      end else begin
        idle(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kb_scan_ctrl.md
# kb_scan_ctrl

Sequencer between the PS/2 receiver and the scan-code-to-ASCII lookup. Consumes raw scan-code bytes, runs the make/break/extended protocol state machine, suppresses typematic repeats and non-key bytes, and queues one key code per physical key press in a small first-word-fall-through FIFO. The downstream text/display logic pops codes with a valid/ready handshake and feeds `key_code` straight into the ASCII lookup.

## Interface
- `FIFO_DEPTH`, 8: key-code queue entries, power of two, 2..16.
- `TIMEOUT`, 50000: cycles allowed between a prefix byte (F0/E0) and its follower before the FSM abandons the sequence.
- `clk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `scan_done_tick`  in  1  one-cycle pulse: `scan_out` holds a new received byte.
- `scan_out`  in  8  received PS/2 byte, valid only with `scan_done_tick`.
- `key_ready`  in  1  downstream accepts the head entry this cycle.
- `key_valid`  out  1  FIFO non-empty; `key_code` is meaningful.
- `key_code`  out  8  head-of-queue scan (make) code.
- `overflow`  out  1  sticky: a key was dropped because the FIFO was full; cleared by the first accepted pop.
- `key_held`  out  1  a non-extended key is currently held down.

## Operation
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
- IDLE: F0 -> BRK; E0 -> EXT; ignored bytes (00, AA, EE, FA, FE, FF) -> stay, nothing queued; any other byte is a make code.
- Make code in IDLE: if `key_held`=1 and code equals the held register -> typematic repeat, discard. Otherwise push code, load held register, set `key_held`.
- BRK: next byte is a break code; if it equals the held register, clear `key_held`; nothing pushed; -> IDLE.
- EXT: F0 -> EXT_BRK; any other byte discarded (extended keys are not mapped) -> IDLE.
- EXT_BRK: next byte discarded -> IDLE.
- Prefix timeout: in BRK/EXT/EXT_BRK, a counter counts cycles since the prefix; on reaching `TIMEOUT` without `scan_done_tick`, -> IDLE, no push, held state unchanged.
- Push to a full FIFO: entry dropped, `overflow` set; held register is still updated (key is logically down).
- Pop: occurs when `key_valid` & `key_ready`; `key_ready` while empty is ignored.

## Timing
- Reset values: state IDLE, FIFO empty, `key_valid`=0, `key_code`=00, `overflow`=0, `key_held`=0, held register 00, timeout counter 0.
- Latency: make code on `scan_done_tick` at cycle N -> `key_valid`=1 with that code at cycle N+1 (FIFO previously empty).
- `key_code` is FWFT: changes only on pop or on push into an empty FIFO; equals 00 whenever empty.
- Simultaneous push and pop when full: pop then push, count unchanged, no overflow.
- Simultaneous push and pop when empty: push only; pop ignored.
- `overflow` set takes priority over clear in the same cycle.
- Count wraps never: pointers are log2(FIFO_DEPTH) bits modulo depth; separate count of log2(FIFO_DEPTH)+1 bits.
- Reset asserted mid-sequence: all state cleared immediately (asynchronous), queued codes lost.
- A byte arriving on the exact cycle the timeout fires is processed in IDLE.

## Structure
- Package `kb_pkg`: constants `KB_BREAK`=F0, `KB_EXT`=E0, ignored-byte constants, FSM state enum.
- Sub-module `kb_fifo`: parameterised FWFT FIFO (push, pop, full, empty, data out); FSM, held register, timeout counter and overflow flag stay in `kb_scan_ctrl`.

## Test plan
- Bytes 1C, F0, 1C with `key_ready`=0 -> exactly one entry, `key_code`=1C, `key_held` 1 then 0 after the break.
- Bytes 1C, 1C, 1C, F0, 1C (typematic) -> one entry 1C; then 1C again -> second entry 1C.
- Bytes E0, 75, E0, F0, 75, then 32 -> only 32 queued; state IDLE at end.
- Nine distinct make codes (16,1E,26,25,2E,36,3D,3E,46) with breaks, `key_ready`=0, depth 8 -> 8 entries 16..3E, `overflow`=1; one pop -> `key_code`=1E, `overflow`=0.
- Byte F0 then no traffic for `TIMEOUT` cycles, then 2D -> 2D queued as a make code.
- Reset pulled low while FIFO holds 3 entries and FSM in BRK -> `key_valid`=0, `key_code`=00, state IDLE; following 5A queued normally.
